mfp_multi_digit_display: RTL



---
 rtl/mfp_display_pkg.sv | 35 +++
 rtl/mfp_hex_to_7seg.sv | 38 +++
 rtl/mfp_multi_digit_display.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mfp_display_pkg.sv
// Shared glyph table and sizing helper for the multi-digit seven-segment driver.
// Glyphs are active-high with bit 0 = segment a ... bit 6 = segment g.
package mfp_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mfp_hex_to_7seg.sv
// Combinational hex nibble to active-high seven-segment glyph, with forced blank.
module mfp_hex_to_7seg
    import mfp_display_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    output logic [6:0] seg
);

    // Glyph lookup; blank overrides the nibble.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (hex)
                4'h0:    seg = SEG_0;
                4'h1:    seg = SEG_1;
                4'h2:    seg = SEG_2;
                4'h3:    seg = SEG_3;
                4'h4:    seg = SEG_4;
                4'h5:    seg = SEG_5;
                4'h6:    seg = SEG_6;
                4'h7:    seg = SEG_7;
                4'h8:    seg = SEG_8;
                4'h9:    seg = SEG_9;
                4'hA:    seg = SEG_A;
                4'hB:    seg = SEG_B;
                4'hC:    seg = SEG_C;
                4'hD:    seg = SEG_D;
                4'hE:    seg = SEG_E;
                4'hF:    seg = SEG_F;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/mfp_multi_digit_display.sv
// N-digit hex display driver: snapshot register, leading-zero blanking, blink,
// static per-digit segment buses and a multiplexed scan port with dead time.
module mfp_multi_digit_display
    import mfp_display_pkg::*;
#(
    parameter int N_DIGITS       = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
)
(
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    blank_lz,
    input  logic [N_DIGITS-1:0]     blink_mask,
    output logic [7*N_DIGITS-1:0]   seg_static,
    output logic [N_DIGITS-1:0]     dp_static,
    output logic [6:0]              seg_scan,
    output logic                    dp_scan,
    output logic [N_DIGITS-1:0]     digit_sel
);

    localparam int PW = clog2(SCAN_DIV);
    localparam int IW = clog2(N_DIGITS);
    localparam int BW = clog2(BLINK_DIV);

    // XOR masks: internal logic is active-high, polarity applied only at the outputs.
    localparam logic [6:0]          SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] DP_POL  = {N_DIGITS{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] SEL_POL = {N_DIGITS{SEL_ACTIVE_LOW}};

    logic [4*N_DIGITS-1:0] value_r;
    logic [N_DIGITS-1:0]   dp_r;
    logic [PW-1:0]         prescaler_r;
    logic [IW-1:0]         index_r;
    logic [BW-1:0]         round_r;
    logic                  phase_r;

    logic [PW-1:0]         prescaler_nxt_s;
    logic [IW-1:0]         index_nxt_s;
    logic                  wrap_s;
    logic                  dead_s;
    logic [N_DIGITS-1:0]   blank_s;
    logic [7*N_DIGITS-1:0] seg_dec_s;
    logic [N_DIGITS-1:0]   dp_dec_s;
    logic [3:0]            scan_hex_s;
    logic                  scan_blank_s;
    logic                  scan_dp_s;
    logic [6:0]            scan_seg_s;
    logic [N_DIGITS-1:0]   sel_oh_s;

    logic [7*N_DIGITS-1:0] seg_static_r;
    logic [N_DIGITS-1:0]   dp_static_r;
    logic [6:0]            seg_scan_r;
    logic                  dp_scan_r;
    logic [N_DIGITS-1:0]   digit_sel_r;

    // Snapshot of value and decimal points on the load strobe.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            value_r <= {(4*N_DIGITS){1'b0}};
            dp_r    <= {N_DIGITS{1'b0}};
        end else if (load) begin
            value_r <= value;
            dp_r    <= dp_in;
        end else begin
            value_r <= value_r;
            dp_r    <= dp_r;
        end
    end

    // Next scan position; wrap_s marks the end of a full round of digits.
    always_comb begin
        prescaler_nxt_s = prescaler_r + PW'(1);
        index_nxt_s     = index_r;
        wrap_s          = 1'b0;
        if (prescaler_r == PW'(SCAN_DIV - 1)) begin
            prescaler_nxt_s = {PW{1'b0}};
            if (index_r == IW'(N_DIGITS - 1)) begin
                index_nxt_s = {IW{1'b0}};
                wrap_s      = 1'b1;
            end else begin
                index_nxt_s = index_r + IW'(1);
            end
        end else begin
            index_nxt_s = index_r;
        end
    end

    // Scan prescaler, digit index and blink phase registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prescaler_r <= {PW{1'b0}};
            index_r     <= {IW{1'b0}};
            round_r     <= {BW{1'b0}};
            phase_r     <= 1'b0;
        end else begin
            prescaler_r <= prescaler_nxt_s;
            index_r     <= index_nxt_s;
            if (wrap_s) begin
                if (round_r == BW'(BLINK_DIV - 1)) begin
                    round_r <= {BW{1'b0}};
                    phase_r <= ~phase_r;
                end else begin
                    round_r <= round_r + BW'(1);
                end
            end else begin
                round_r <= round_r;
            end
        end
    end

    // Per-digit blanking: leading-zero run from the top digit (a set dp stops it) plus blink.
    always_comb begin
        logic run_v;
        run_v   = 1'b1;
        blank_s = {N_DIGITS{1'b0}};
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run_v      = run_v && (value_r[4*i +: 4] == 4'h0) && !dp_r[i];
            blank_s[i] = (blank_lz && run_v && (i != 0)) || (phase_r && blink_mask[i]);
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_static_dec
        mfp_hex_to_7seg u_dec (
            .hex   (value_r[4*g +: 4]),
            .blank (blank_s[g]),
            .seg   (seg_dec_s[7*g +: 7])
        );
    end

    assign dp_dec_s = dp_r & ~blank_s;

    // Select the digit that will be shown in the next cycle of the scan.
    always_comb begin
        scan_hex_s   = 4'h0;
        scan_blank_s = 1'b1;
        scan_dp_s    = 1'b0;
        sel_oh_s     = {N_DIGITS{1'b0}};
        for (int i = 0; i < N_DIGITS; i++) begin
            if (index_nxt_s == IW'(i)) begin
                scan_hex_s   = value_r[4*i +: 4];
                scan_blank_s = blank_s[i];
                scan_dp_s    = dp_dec_s[i];
                sel_oh_s[i]  = 1'b1;
            end else begin
                sel_oh_s[i]  = 1'b0;
            end
        end
    end

    mfp_hex_to_7seg u_scan_dec (
        .hex   (scan_hex_s),
        .blank (scan_blank_s),
        .seg   (scan_seg_s)
    );

    // First cycle of every slot is dead time so the outgoing digit does not ghost.
    assign dead_s = (prescaler_nxt_s == {PW{1'b0}});

    // Output registers with polarity applied.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            seg_static_r <= {N_DIGITS{SEG_POL}};
            dp_static_r  <= DP_POL;
            seg_scan_r   <= SEG_POL;
            dp_scan_r    <= SEG_ACTIVE_LOW;
            digit_sel_r  <= SEL_POL;
        end else begin
            seg_static_r <= seg_dec_s ^ {N_DIGITS{SEG_POL}};
            dp_static_r  <= dp_dec_s ^ DP_POL;
            if (dead_s) begin
                seg_scan_r  <= SEG_POL;
                dp_scan_r   <= SEG_ACTIVE_LOW;
                digit_sel_r <= SEL_POL;
            end else begin
                seg_scan_r  <= scan_seg_s ^ SEG_POL;
                dp_scan_r   <= scan_dp_s ^ SEG_ACTIVE_LOW;
                digit_sel_r <= sel_oh_s ^ SEL_POL;
            end
        end
    end

    assign seg_static = seg_static_r;
    assign dp_static  = dp_static_r;
    assign seg_scan   = seg_scan_r;
    assign dp_scan    = dp_scan_r;
    assign digit_sel  = digit_sel_r;

endmodule
